// File: rtl/video_sync_pkg.sv
// Shared state encoding, default timing constants and counter widths for the sync decoder.
package video_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam int DEF_LINE_LEN  = 592;
    localparam int DEF_TOL       = 2;
    localparam int DEF_HS_MIN    = 16;
    localparam int DEF_VS_MIN    = 200;
    localparam int DEF_LOCK_CNT  = 4;
    localparam int DEF_LINES_MAX = 625;

    localparam int WCNT_W = 9;
    localparam int CNT_W  = 10;
    localparam int GOOD_W = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_meter.sv
// Purpose: double-samples csync and measures low widths, flagging H, V and short-pulse-end events.
// Latency: h_evt is combinational in the cycle the width counter reaches HS_MIN (csync fall + HS_MIN+1).
// Backpressure: none, free-running on every clock.
module sync_edge_meter
    import video_sync_pkg::*;
#(
    parameter int HS_MIN = DEF_HS_MIN,
    parameter int VS_MIN = DEF_VS_MIN
) (
    input  logic CK,
    input  logic RST,
    input  logic csync,
    output logic h_evt,
    output logic v_evt,
    output logic short_end
);

    localparam logic [WCNT_W-1:0] HS_W = WCNT_W'(HS_MIN);
    localparam logic [WCNT_W-1:0] VS_W = WCNT_W'(VS_MIN);

    logic              s1;
    logic              s2;
    logic [WCNT_W-1:0] wcnt;

    always_ff @(posedge CK) begin
        if (RST) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            wcnt <= '0;
        end else begin
            s1 <= csync;
            s2 <= s1;
            if (s1) begin
                wcnt <= '0;
            end else if (wcnt != {WCNT_W{1'b1}}) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    assign h_evt = (wcnt == HS_W);
    assign v_evt = (wcnt == VS_W);

    // On the first high sample wcnt still holds the full width of the pulse that just ended.
    assign short_end = s1 && !s2 && (wcnt >= HS_W) && (wcnt < VS_W);

endmodule

// File: rtl/video_sync_decoder.sv
// Purpose: composite-sync decoder that locks onto the line period and tracks line/frame position.
// Latency: line_start follows the raw csync fall by HS_MIN+2 cycles; frame_start one cycle after a V event.
// Backpressure: none, outputs are pulses/levels with no handshake.
module video_sync_decoder
    import video_sync_pkg::*;
#(
    parameter int LINE_LEN  = DEF_LINE_LEN,
    parameter int TOL       = DEF_TOL,
    parameter int HS_MIN    = DEF_HS_MIN,
    parameter int VS_MIN    = DEF_VS_MIN,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int LINES_MAX = DEF_LINES_MAX
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             csync,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             line_start,
    output logic             frame_start,
    output logic             vsync,
    output logic             locked,
    output logic             sync_err
);

    localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(LINE_LEN - TOL);
    localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(LINE_LEN + TOL);
    localparam logic [CNT_W-1:0]  TMO_LEN   = CNT_W'(LINE_LEN + TOL + 1);
    localparam logic [CNT_W-1:0]  HCNT_LOAD = CNT_W'(HS_MIN);
    localparam logic [CNT_W-1:0]  VCNT_LAST = CNT_W'(LINES_MAX - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

    logic              h_evt;
    logic              v_evt;
    logic              short_end;
    logic [CNT_W-1:0]  pcnt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;
    logic              in_win;
    logic              timeout;
    logic              lose;
    sync_state_t       state;

    sync_edge_meter #(
        .HS_MIN (HS_MIN),
        .VS_MIN (VS_MIN)
    ) u_meter (
        .CK        (CK),
        .RST       (RST),
        .csync     (csync),
        .h_evt     (h_evt),
        .v_evt     (v_evt),
        .short_end (short_end)
    );

    // pcnt restarts at 1 so that at the next H event it equals the cycles elapsed since this one.
    always_ff @(posedge CK) begin
        if (RST) begin
            hcnt <= '0;
            pcnt <= '0;
        end else begin
            hcnt <= h_evt ? HCNT_LOAD : sat_inc(hcnt);
            pcnt <= h_evt ? CNT_W'(1) : sat_inc(pcnt);
        end
    end

    assign in_win   = (pcnt >= WIN_LO) && (pcnt <= WIN_HI);
    assign timeout  = (pcnt >= TMO_LEN);
    assign good_nxt = good + 1'b1;

    // An H event always takes precedence over a coincident timeout.
    always_comb begin
        lose = 1'b0;
        if (state == LOCKED) begin
            if (h_evt) begin
                lose = !in_win || (vcnt >= VCNT_LAST);
            end else begin
                lose = timeout;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state       <= HUNT;
            good        <= '0;
            vcnt        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vsync       <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            case (state)
                HUNT: begin
                    if (h_evt) begin
                        state <= TRACK;
                        good  <= '0;
                    end
                end
                TRACK: begin
                    if (h_evt) begin
                        if (!in_win) begin
                            good <= '0;
                        end else begin
                            good <= good_nxt;
                            if (good_nxt == GOOD_LOCK) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                vcnt   <= '0;
                                vsync  <= 1'b0;
                            end
                        end
                    end else if (timeout) begin
                        state <= HUNT;
                        good  <= '0;
                    end
                end
                LOCKED: begin
                    if (lose) begin
                        state    <= HUNT;
                        good     <= '0;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                        vcnt     <= '0;
                        vsync    <= 1'b0;
                    end else begin
                        if (h_evt) begin
                            line_start <= 1'b1;
                            vcnt       <= vcnt + 1'b1;
                        end
                        if (v_evt) begin
                            vcnt        <= '0;
                            frame_start <= 1'b1;
                            vsync       <= 1'b1;
                        end
                        if (short_end) begin
                            vsync <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    good   <= '0;
                    locked <= 1'b0;
                    vcnt   <= '0;
                    vsync  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed line-by-line stimulus for the composite sync decoder with hand-computed expectations.
`timescale 1ns/1ps
module tb_video_sync_decoder;

    logic       CK = 1'b0;
    logic       RST;
    logic       csync;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       line_start;
    logic       frame_start;
    logic       vsync;
    logic       locked;
    logic       sync_err;

    video_sync_decoder dut (
        .CK          (CK),
        .RST         (RST),
        .csync       (csync),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .line_start  (line_start),
        .frame_start (frame_start),
        .vsync       (vsync),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 CK = ~CK;

    typedef struct {
        int period;
        int low;
        int glitch_at;
        int exp_ls;
        int exp_fs;
        int exp_err;
        int exp_locked;
        int exp_vcnt;
        int exp_vsync;
        int exp_vs_ls;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    int ls_cnt;
    int fs_cnt;
    int err_cnt;
    int h_at_ls;
    int h_prev;
    int vs_at_ls;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One line: csync low for 'low' cycles from the line start, optional 8-cycle glitch, high otherwise.
    task automatic run_line(input int period, input int low, input int glitch_at);
        int prev;
        ls_cnt   = 0;
        fs_cnt   = 0;
        err_cnt  = 0;
        h_at_ls  = -1;
        h_prev   = -1;
        vs_at_ls = 0;
        prev     = int'(hcnt);
        for (int i = 0; i < period; i++) begin
            @(posedge CK);
            #1;
            if (line_start) begin
                ls_cnt++;
                h_at_ls  = int'(hcnt);
                h_prev   = prev;
                vs_at_ls = int'(vsync);
            end
            fs_cnt  += int'(frame_start);
            err_cnt += int'(sync_err);
            prev     = int'(hcnt);
            csync = (i < low || (glitch_at > 0 && i >= glitch_at && i < glitch_at + 8)) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        int ls_sum;
        int err_sum;
        int ls_step;
        int err_step;
        int e;

        //              period low glitch  ls fs err lock vcnt vsync vs@ls
        vecs[0]  = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[1]  = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[2]  = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[3]  = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[4]  = '{592, 40,   0,   0, 0, 0,  1,  0,   0,   0};
        vecs[5]  = '{592, 40,   0,   1, 0, 0,  1,  1,   0,   0};
        vecs[6]  = '{592, 40, 302,   1, 0, 0,  1,  2,   0,   0};
        vecs[7]  = '{592, 250,  0,   1, 1, 0,  1,  0,   1,   0};
        vecs[8]  = '{592, 40,   0,   1, 0, 0,  1,  1,   0,   1};
        vecs[9]  = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[10] = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[11] = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[12] = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[13] = '{592, 40,   0,   0, 0, 0,  1,  0,   0,   0};
        vecs[14] = '{580, 40,   0,   1, 0, 0,  1,  1,   0,   0};
        vecs[15] = '{592, 40,   0,   0, 0, 1,  0,  0,   0,   0};
        vecs[16] = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[17] = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[18] = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[19] = '{592, 40,   0,   0, 0, 0,  0,  0,   0,   0};
        vecs[20] = '{592, 40,   0,   0, 0, 0,  1,  0,   0,   0};

        csync = 1'b1;
        RST   = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        chk("reset_hcnt", int'(hcnt), 0);
        chk("reset_vcnt", int'(vcnt), 0);
        chk("reset_line_start", int'(line_start), 0);
        chk("reset_frame_start", int'(frame_start), 0);
        chk("reset_vsync", int'(vsync), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_sync_err", int'(sync_err), 0);
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (i == 9) begin
                // Run locked lines up to vcnt=100, then a one-cycle reset mid-frame.
                ls_sum  = 0;
                err_sum = 0;
                for (int k = 0; k < 99; k++) begin
                    run_line(592, 40, 0);
                    ls_sum  += ls_cnt;
                    err_sum += err_cnt;
                end
                chk("bulk_line_starts", ls_sum, 99);
                chk("bulk_sync_err", err_sum, 0);
                chk("bulk_vcnt", int'(vcnt), 100);
                chk("bulk_locked", int'(locked), 1);
                @(posedge CK);
                #1;
                RST = 1'b1;
                @(posedge CK);
                #1;
                chk("rst_mid_hcnt", int'(hcnt), 0);
                chk("rst_mid_vcnt", int'(vcnt), 0);
                chk("rst_mid_ls", int'(line_start), 0);
                chk("rst_mid_fs", int'(frame_start), 0);
                chk("rst_mid_vsync", int'(vsync), 0);
                chk("rst_mid_locked", int'(locked), 0);
                chk("rst_mid_err", int'(sync_err), 0);
                RST = 1'b0;
            end
            run_line(vecs[i].period, vecs[i].low, vecs[i].glitch_at);
            chk($sformatf("v%0d_line_start", i), ls_cnt, vecs[i].exp_ls);
            chk($sformatf("v%0d_frame_start", i), fs_cnt, vecs[i].exp_fs);
            chk($sformatf("v%0d_sync_err", i), err_cnt, vecs[i].exp_err);
            chk($sformatf("v%0d_locked", i), int'(locked), vecs[i].exp_locked);
            chk($sformatf("v%0d_vcnt", i), int'(vcnt), vecs[i].exp_vcnt);
            chk($sformatf("v%0d_vsync", i), int'(vsync), vecs[i].exp_vsync);
            if (vecs[i].exp_ls == 1) begin
                chk($sformatf("v%0d_hcnt_at_ls", i), h_at_ls, 16);
                chk($sformatf("v%0d_hcnt_before_ls", i), h_prev, 607);
                chk($sformatf("v%0d_vsync_at_ls", i), vs_at_ls, vecs[i].exp_vs_ls);
            end
        end

        // Locked, one last pulse, then csync stays high until the timeout fires.
        ls_step  = -1;
        err_step = -1;
        e        = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge CK);
            #1;
            if (line_start && ls_step < 0) ls_step = i;
            if (sync_err) begin
                e++;
                if (err_step < 0) err_step = i;
            end
            csync = (i < 40) ? 1'b0 : 1'b1;
        end
        chk("timeout_ls_latency", ls_step, 18);
        chk("timeout_delay", err_step - ls_step, 595);
        chk("timeout_err_pulses", e, 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_vcnt", int'(vcnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
